// File: rtl/rf_mp_pkg.sv
// Shared CPU parameter package: register-file geometry used by the
// register file and the rest of the datapath.
package rf_mp_pkg;

   localparam int RF_DATA_W = 32;
   localparam int RF_ADDR_W = 5;
   localparam int RF_NRD    = 2;
   localparam int RF_NWR    = 2;

   typedef logic [RF_DATA_W-1:0] rfWord_t;
   typedef logic [RF_ADDR_W-1:0] rfAddr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write (busy) bits with one reservation port,
// NWR clear ports and NRD combinational query ports.
module rf_scoreboard import rf_mp_pkg::*; #(
   parameter int ADDR_W = RF_ADDR_W,
   parameter int NWR    = RF_NWR,
   parameter int NRD    = RF_NRD
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  setEn,
   input  logic [ADDR_W-1:0]     setAddr,
   input  logic [NWR-1:0]        clrEn,
   input  logic [NWR*ADDR_W-1:0] clrAddr,
   input  logic [NRD*ADDR_W-1:0] qAddr,
   output logic [NRD-1:0]        qBusy
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busyNext;

   // Clears are applied before the set so a new producer reserving the
   // register in the same cycle keeps it busy; r0 can never be busy.
   always_comb begin
      busyNext = busy;
      for (int k = 0; k < NWR; k++) begin
         if (clrEn[k]) busyNext[clrAddr[k*ADDR_W +: ADDR_W]] = 1'b0;
      end
      if (setEn) busyNext[setAddr] = 1'b1;
      busyNext[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) busy <= '0;
      else     busy <= busyNext;
   end

   always_comb begin
      qBusy = '0;
      for (int p = 0; p < NRD; p++) begin
         qBusy[p] = busy[qAddr[p*ADDR_W +: ADDR_W]];
      end
   end

endmodule

// File: rtl/rf_mp.sv
// Multi-port register file with write-first bypass, hardwired-zero r0
// and a scoreboard reporting pending writes per read port.
module rf_mp import rf_mp_pkg::*; #(
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W,
   parameter int NRD    = RF_NRD,
   parameter int NWR    = RF_NWR
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NWR-1:0]        we,
   input  logic [NWR*ADDR_W-1:0] waddr,
   input  logic [NWR*DATA_W-1:0] wdata,
   input  logic [NRD*ADDR_W-1:0] raddr,
   output logic [NRD*DATA_W-1:0] rdata,
   input  logic                  iss_en,
   input  logic [ADDR_W-1:0]     iss_addr,
   output logic [NRD-1:0]        rbusy
);

   localparam int DEPTH = 1 << ADDR_W;

   if (DATA_W < 1 || ADDR_W < 1 || NRD < 1 || NRD > 4 || NWR < 1 || NWR > 2) begin : gBadParam
      $error("rf_mp: parameter out of range (DATA_W=%0d ADDR_W=%0d NRD=%0d NWR=%0d)",
             DATA_W, ADDR_W, NRD, NWR);
   end

   logic [DEPTH-1:0][DATA_W-1:0] mem;
   logic [NWR-1:0]               wrLive;
   logic [NRD-1:0]               sbBusy;
   logic [NRD-1:0]               rdHit;

   // A write to r0 is dropped here so neither storage nor the scoreboard sees it.
   always_comb begin
      wrLive = '0;
      for (int k = 0; k < NWR; k++) begin
         wrLive[k] = we[k] && (waddr[k*ADDR_W +: ADDR_W] != '0);
      end
   end

   // Higher-numbered write ports are assigned last, so they win on collisions.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem <= '0;
      end else begin
         for (int k = 0; k < NWR; k++) begin
            if (wrLive[k]) mem[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
         end
      end
   end

   // Read path: storage, overridden by any same-cycle write to the address.
   always_comb begin
      rdata = '0;
      rdHit = '0;
      for (int p = 0; p < NRD; p++) begin
         if (raddr[p*ADDR_W +: ADDR_W] != '0) begin
            rdata[p*DATA_W +: DATA_W] = mem[raddr[p*ADDR_W +: ADDR_W]];
            for (int k = 0; k < NWR; k++) begin
               if (wrLive[k] && (waddr[k*ADDR_W +: ADDR_W] == raddr[p*ADDR_W +: ADDR_W])) begin
                  rdata[p*DATA_W +: DATA_W] = wdata[k*DATA_W +: DATA_W];
                  rdHit[p] = 1'b1;
               end
            end
         end
      end
   end

   rf_scoreboard #(
      .ADDR_W(ADDR_W),
      .NWR   (NWR),
      .NRD   (NRD)
   ) uScoreboard (
      .clk    (clk),
      .rst    (rst),
      .setEn  (iss_en && (iss_addr != '0)),
      .setAddr(iss_addr),
      .clrEn  (wrLive),
      .clrAddr(waddr),
      .qAddr  (raddr),
      .qBusy  (sbBusy)
   );

   // A value being written this cycle is already forwarded, so it is not pending.
   always_comb begin
      rbusy = '0;
      for (int p = 0; p < NRD; p++) begin
         rbusy[p] = sbBusy[p] && !rdHit[p] && (raddr[p*ADDR_W +: ADDR_W] != '0);
      end
   end

endmodule
